// File: rtl/pipeline_mux_stage_if.sv
// Data/enable bundle for one pipeline mux stage.
// The master drives en and in; the stage drives out.
interface pipeline_mux_stage_if #(
    parameter int unsigned WIDTH = 18
);
    logic             en;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    modport master (output en, output in, input out);
    modport slave  (input en, input in, output out);
endinterface

// File: rtl/pipeline_mux_stage.sv
// Optional clock-enabled pipeline register (DSP48A1-style pipeline mux).
// PIPELINE_ENABLE picks a registered stage or a combinational bypass at elaboration.
module pipeline_mux_stage #(
    parameter int unsigned WIDTH           = 18,
    parameter bit          PIPELINE_ENABLE = 1'b1,
    parameter              RSTTYPE         = "ASYNC"
) (
    input logic                clk,
    input logic                rst,
    pipeline_mux_stage_if.slave bus
);

    if (RSTTYPE != "ASYNC") begin : g_bad_rsttype
        $error("pipeline_mux_stage: RSTTYPE must be \"ASYNC\"");
    end

    if (PIPELINE_ENABLE) begin : g_reg
        logic [WIDTH-1:0] q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q <= '0;
            end else if (bus.en) begin
                q <= bus.in;
            end
        end

        assign bus.out = q;
    end else begin : g_bypass
        // clk, rst and en have no role in the bypass path.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, bus.en};
        assign bus.out     = bus.in;
    end

endmodule

// File: tb/tb_pipeline_mux_stage.sv
// Directed and random checks of pipeline_mux_stage in registered (4/18-bit)
// and bypass configurations.
module tb_pipeline_mux_stage;

    logic clk = 1'b0;
    logic rst4, rst18, rst_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipeline_mux_stage_if #(.WIDTH(4))  bus4 ();
    pipeline_mux_stage_if #(.WIDTH(18)) bus18 ();
    pipeline_mux_stage_if #(.WIDTH(4))  busb ();

    pipeline_mux_stage #(.WIDTH(4), .PIPELINE_ENABLE(1'b1), .RSTTYPE("ASYNC")) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4.slave)
    );

    pipeline_mux_stage #(.WIDTH(18), .PIPELINE_ENABLE(1'b1), .RSTTYPE("ASYNC")) dut18 (
        .clk (clk),
        .rst (rst18),
        .bus (bus18.slave)
    );

    pipeline_mux_stage #(.WIDTH(4), .PIPELINE_ENABLE(1'b0), .RSTTYPE("ASYNC")) dutb (
        .clk (clk),
        .rst (rst_b),
        .bus (busb.slave)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] in;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic [3:0] i,
                                input logic [3:0] x);
        vec_t v;
        v.rst = r;
        v.en  = e;
        v.in  = i;
        v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] model;

        rst4 = 1'b0; bus4.en = 1'b0; bus4.in = '0;
        rst18 = 1'b0; bus18.en = 1'b0; bus18.in = '0;
        rst_b = 1'b0; busb.en = 1'b0; busb.in = '0;

        // reset held, then release
        add(0, 1, 4'hF, 4'h0);
        add(0, 1, 4'hF, 4'h0);
        add(0, 1, 4'hF, 4'h0);
        add(1, 1, 4'hF, 4'hF);
        // enabled capture
        add(1, 1, 4'h3, 4'h3);
        add(1, 1, 4'h9, 4'h9);
        add(1, 1, 4'hC, 4'hC);
        // enable hold
        add(1, 1, 4'hA, 4'hA);
        for (int unsigned k = 0; k < 4; k++) add(1, 0, 4'h5, 4'hA);
        add(1, 1, 4'h5, 4'h5);
        add(1, 1, 4'h7, 4'h7);

        @(negedge clk);
        check("reset_initial", bus4.out, 18'h0);
        foreach (vecs[i]) begin
            rst4    = vecs[i].rst;
            bus4.en = vecs[i].en;
            bus4.in = vecs[i].in;
            @(negedge clk);
            check($sformatf("vec%0d", i), bus4.out, vecs[i].exp);
        end

        // async reset pulse between edges, out was 7
        @(posedge clk);
        #2 rst4 = 1'b0;
        #1 check("async_clear", bus4.out, 18'h0);
        @(negedge clk);
        check("async_held", bus4.out, 18'h0);
        rst4 = 1'b1; bus4.en = 1'b0; bus4.in = 4'h9;
        @(negedge clk);
        check("post_release_en0", bus4.out, 18'h0);
        bus4.en = 1'b1;
        @(negedge clk);
        check("post_release_en1", bus4.out, 18'h9);

        // reset coincident with a rising edge
        bus4.in = 4'hE;
        @(posedge clk);
        rst4 = 1'b0;
        #1 check("reset_at_edge", bus4.out, 18'h0);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        check("reset_at_edge_recover", bus4.out, 18'hE);

        // random in/en against a hold/capture model
        model = 4'hE;
        for (int unsigned k = 0; k < 20; k++) begin
            bus4.en = 1'($urandom);
            bus4.in = 4'($urandom);
            if (bus4.en) model = bus4.in;
            @(negedge clk);
            check($sformatf("rand%0d", k), bus4.out, model);
        end

        // full width pass-through
        rst18 = 1'b1; bus18.en = 1'b1; bus18.in = 18'h3FFFF;
        @(negedge clk);
        check("w18_ones", bus18.out, 18'h3FFFF);
        bus18.in = 18'h2A5C3;
        @(negedge clk);
        check("w18_pattern", bus18.out, 18'h2A5C3);

        // bypass follows in with clock-independent timing
        @(posedge clk);
        #1 busb.in = 4'h0;
        #1 check("bypass_0", busb.out, 18'h0);
        busb.in = 4'h6;
        #1 check("bypass_6", busb.out, 18'h6);
        busb.in = 4'hB;
        #1 check("bypass_B", busb.out, 18'hB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
